ex_muldiv_unit: RTL and testbench

- EX-stage consumer of the forwarding unit's ForwardA/ForwardB selects.
- Muxes the forwarded ALU operands and hosts the iterative multiply/divide engine with the HI/LO registers.
- Raises a stall toward the hazard/IF-ID logic while a multi-cycle operation blocks a dependent instruction.

---
 rtl/ex_muldiv_unit_pkg.sv | 30 +++
 rtl/ex_muldiv_unit_operand_fwd_mux.sv | 26 ++
 rtl/ex_muldiv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit and its forwarding muxes.
package ex_muldiv_unit_pkg;

    // md_op encodings; any other value behaves as MD_NONE
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    // Forwarding-unit select values; 2'b11 falls back to the ID/EX value
    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Engine states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    // True for every encoding that names a real multiply/divide operation
    function automatic logic md_is_op(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_MTLO);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_operand_fwd_mux.sv
// Three-source forwarding mux for one ALU operand.
module ex_muldiv_unit_operand_fwd_mux
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned W = 32
)
(
    input  logic [1:0]   sel,
    input  logic [W-1:0] id_ex,
    input  logic [W-1:0] ex_mem,
    input  logic [W-1:0] mem_wb,
    output logic [W-1:0] operand
);

    // Pick the newest producer named by the forwarding unit
    always_comb begin
        operand = id_ex;
        case (sel)
            FWD_IDEX:  operand = id_ex;
            FWD_EXMEM: operand = ex_mem;
            FWD_MEMWB: operand = mem_wb;
            default:   operand = id_ex;
        endcase
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage operand forwarding plus iterative MULT/DIV engine with HI/LO.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MD_CYCLES = 32
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      ForwardA,
    input  logic [1:0]      ForwardB,
    input  logic [XLEN-1:0] ID_EX_ReadData1,
    input  logic [XLEN-1:0] ID_EX_ReadData2,
    input  logic [XLEN-1:0] EX_MEM_ALUResult,
    input  logic [XLEN-1:0] MEM_WB_WriteData,
    input  logic            ex_valid,
    input  logic            flush,
    input  logic [3:0]      md_op,
    output logic [XLEN-1:0] OperandA,
    output logic [XLEN-1:0] OperandB,
    output logic [XLEN-1:0] md_result,
    output logic            md_stall,
    output logic            md_busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned CW = $clog2(MD_CYCLES);

    logic [1:0]        state, state_n;
    logic [CW-1:0]     count, count_n;
    logic [XLEN-1:0]   opnd, opnd_n;       // multiplicand or divisor magnitude
    logic [XLEN-1:0]   acc_hi, acc_hi_n;   // partial product high / remainder
    logic [XLEN-1:0]   acc_lo, acc_lo_n;   // multiplier shifting out / quotient shifting in
    logic              neg_q, neg_q_n;     // negate product or quotient
    logic              neg_r, neg_r_n;     // negate remainder
    logic              dz, dz_n;           // divide by zero
    logic [XLEN-1:0]   hi_n, lo_n;

    logic              issue;
    logic              last;
    logic              signed_op;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   div_quo;

    ex_muldiv_unit_operand_fwd_mux #(.W(XLEN)) u_fwd_a (
        .sel     (ForwardA),
        .id_ex   (ID_EX_ReadData1),
        .ex_mem  (EX_MEM_ALUResult),
        .mem_wb  (MEM_WB_WriteData),
        .operand (OperandA)
    );

    ex_muldiv_unit_operand_fwd_mux #(.W(XLEN)) u_fwd_b (
        .sel     (ForwardB),
        .id_ex   (ID_EX_ReadData2),
        .ex_mem  (EX_MEM_ALUResult),
        .mem_wb  (MEM_WB_WriteData),
        .operand (OperandB)
    );

    // Issue qualification and hazard stall toward IF/ID
    assign issue    = ex_valid & ~flush & md_is_op(md_op);
    assign md_busy  = (state != ST_IDLE);
    assign md_stall = issue & md_busy;
    assign last     = (count == CW'(MD_CYCLES - 1));

    // Signed ops work on magnitudes; the sign is restored on the final edge
    assign signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign a_neg     = signed_op & OperandA[XLEN-1];
    assign b_neg     = signed_op & OperandB[XLEN-1];
    assign a_mag     = a_neg ? -OperandA : OperandA;
    assign b_mag     = b_neg ? -OperandB : OperandB;

    // One shift-add step: add multiplicand on multiplier LSB, shift pair right
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    assign mul_step = {mul_sum, acc_lo[XLEN-1:1]};
    assign mul_prod = neg_q ? -mul_step : mul_step;

    // One restoring-division step, dividend consumed MSB first
    assign div_sh   = {acc_hi, acc_lo[XLEN-1]};
    assign div_ge   = (div_sh >= {1'b0, opnd});
    assign div_diff = div_sh - {1'b0, opnd};
    assign div_rem  = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    assign div_quo  = {acc_lo[XLEN-2:0], div_ge};

    // HI/LO read port for MFHI/MFLO
    always_comb begin
        md_result = '0;
        if (md_op == MD_MFHI) begin
            md_result = hi;
        end else if (md_op == MD_MFLO) begin
            md_result = lo;
        end
    end

    // Next-state and datapath update for the engine
    always_comb begin
        state_n  = state;
        count_n  = count;
        opnd_n   = opnd;
        acc_hi_n = acc_hi;
        acc_lo_n = acc_lo;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        dz_n     = dz;
        hi_n     = hi;
        lo_n     = lo;
        case (state)
            ST_IDLE: begin
                if (issue) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            state_n  = ST_MUL;
                            count_n  = '0;
                            opnd_n   = a_mag;
                            acc_hi_n = '0;
                            acc_lo_n = b_mag;
                            neg_q_n  = a_neg ^ b_neg;
                            neg_r_n  = 1'b0;
                            dz_n     = 1'b0;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_n  = ST_DIV;
                            count_n  = '0;
                            opnd_n   = b_mag;
                            acc_hi_n = '0;
                            acc_lo_n = a_mag;
                            neg_q_n  = a_neg ^ b_neg;
                            neg_r_n  = a_neg;
                            dz_n     = (OperandB == '0);
                        end
                        MD_MTHI: hi_n = OperandA;
                        MD_MTLO: lo_n = OperandA;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                acc_hi_n = mul_step[2*XLEN-1:XLEN];
                acc_lo_n = mul_step[XLEN-1:0];
                count_n  = count + CW'(1);
                if (last) begin
                    hi_n    = mul_prod[2*XLEN-1:XLEN];
                    lo_n    = mul_prod[XLEN-1:0];
                    count_n = '0;
                    state_n = ST_IDLE;
                end
            end
            ST_DIV: begin
                acc_hi_n = div_rem;
                acc_lo_n = div_quo;
                count_n  = count + CW'(1);
                if (last) begin
                    // Divide by zero leaves an all-ones quotient; remainder fix-up yields the dividend
                    lo_n    = dz ? '1 : (neg_q ? -div_quo : div_quo);
                    hi_n    = neg_r ? -div_rem : div_rem;
                    count_n = '0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            opnd   <= opnd_n;
            acc_hi <= acc_hi_n;
            acc_lo <= acc_lo_n;
            neg_q  <= neg_q_n;
            neg_r  <= neg_r_n;
            dz     <= dz_n;
            hi     <= hi_n;
            lo     <= lo_n;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit against an arithmetic reference.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, EX_MEM_ALUResult, MEM_WB_WriteData;
    logic        ex_valid, flush;
    logic [3:0]  md_op;
    logic [31:0] OperandA, OperandB, md_result, hi, lo;
    logic        md_stall, md_busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32), .MD_CYCLES(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .ForwardA         (ForwardA),
        .ForwardB         (ForwardB),
        .ID_EX_ReadData1  (ID_EX_ReadData1),
        .ID_EX_ReadData2  (ID_EX_ReadData2),
        .EX_MEM_ALUResult (EX_MEM_ALUResult),
        .MEM_WB_WriteData (MEM_WB_WriteData),
        .ex_valid         (ex_valid),
        .flush            (flush),
        .md_op            (md_op),
        .OperandA         (OperandA),
        .OperandB         (OperandB),
        .md_result        (md_result),
        .md_stall         (md_stall),
        .md_busy          (md_busy),
        .hi               (hi),
        .lo               (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Forwarding select as the forwarding unit defines it
    function automatic logic [31:0] fwd_ref(input logic [1:0] s, input logic [31:0] idex,
                                            input logic [31:0] exmem, input logic [31:0] memwb);
        if (s == 2'b10) return exmem;
        if (s == 2'b01) return memwb;
        return idex;
    endfunction

    // {hi,lo} from plain 64-bit arithmetic
    function automatic logic [63:0] md_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MULT:  return 64'(sa * sb);
            MD_MULTU: return 64'(ua * ub);
            MD_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            MD_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return {m_hi, m_lo};
        endcase
    endfunction

    task automatic idle_inputs();
        ex_valid = 1'b0;
        flush    = 1'b0;
        md_op    = MD_NONE;
        ForwardA = FWD_IDEX;
        ForwardB = FWD_IDEX;
    endtask

    // Issue one MULT/DIV, optionally with non-issuing traffic while busy, and check it
    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit noise);
        logic [63:0] exp;
        int          cyc;
        bit          held, no_stall;
        exp = md_ref(op, a, b);
        ForwardA = FWD_IDEX;
        ForwardB = FWD_IDEX;
        ID_EX_ReadData1 = a;
        ID_EX_ReadData2 = b;
        ex_valid = 1'b1;
        flush    = 1'b0;
        md_op    = op;
        step();
        idle_inputs();
        cyc      = 0;
        held     = 1'b1;
        no_stall = 1'b1;
        while (md_busy === 1'b1 && cyc < 200) begin
            if (hi !== m_hi || lo !== m_lo) held = 1'b0;
            if (noise) begin
                ex_valid = 1'b1;
                if ($urandom_range(0, 1) == 0) begin
                    flush = 1'b1;
                    md_op = 4'($urandom_range(0, 15));
                end else begin
                    flush = 1'b0;
                    md_op = ($urandom_range(0, 1) == 0) ? MD_NONE : 4'($urandom_range(9, 15));
                end
                #1;
                if (md_stall !== 1'b0) no_stall = 1'b0;
            end
            step();
            cyc++;
        end
        idle_inputs();
        check({tag, " latency"}, 64'(cyc), 64'(32));
        check({tag, " hilo_held"}, 64'(held), 64'(1));
        if (noise) check({tag, " no_stall"}, 64'(no_stall), 64'(1));
        check({tag, " hilo"}, {hi, lo}, exp);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        logic [63:0] exp;
        logic [31:0] ra, rb, rc, rd;
        logic [1:0]  sa, sb;
        int          cyc;
        bit          track;

        rst = 1'b1;
        ID_EX_ReadData1 = '0; ID_EX_ReadData2 = '0;
        EX_MEM_ALUResult = '0; MEM_WB_WriteData = '0;
        idle_inputs();
        repeat (3) step();
        check("rst hi", 64'(hi), 64'(0));
        check("rst lo", 64'(lo), 64'(0));
        check("rst busy", 64'(md_busy), 64'(0));
        check("rst stall", 64'(md_stall), 64'(0));
        rst = 1'b0;
        step();

        // Directed forwarding cases
        ForwardA = 2'b10; EX_MEM_ALUResult = 32'h1234; ID_EX_ReadData1 = 32'h5;
        ForwardB = 2'b01; MEM_WB_WriteData = 32'hAA; ID_EX_ReadData2 = 32'h77;
        #1;
        check("fwdA exmem", 64'(OperandA), 64'(32'h1234));
        check("fwdB memwb", 64'(OperandB), 64'(32'hAA));
        ForwardB = 2'b11;
        #1;
        check("fwdB sel11", 64'(OperandB), 64'(32'h77));

        // Random forwarding
        for (int i = 0; i < 12; i++) begin
            sa = 2'($urandom_range(0, 3)); sb = 2'($urandom_range(0, 3));
            ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
            ForwardA = sa; ForwardB = sb;
            ID_EX_ReadData1 = ra; ID_EX_ReadData2 = rb;
            EX_MEM_ALUResult = rc; MEM_WB_WriteData = rd;
            #1;
            check("fwdA rand", 64'(OperandA), 64'(fwd_ref(sa, ra, rc, rd)));
            check("fwdB rand", 64'(OperandB), 64'(fwd_ref(sb, rb, rc, rd)));
        end
        idle_inputs();
        step();

        // Directed multiply/divide and boundary cases
        run_md("mult -2x3",   MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
        run_md("multu -2x3",  MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_md("div -7/2",    MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        run_md("divu 7/0",    MD_DIVU,  32'd7,         32'd0, 1'b0);
        run_md("div -5/0",    MD_DIV,   32'hFFFF_FFFB, 32'd0, 1'b0);
        run_md("div min/-1",  MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_md("mult min^2",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b1);
        run_md("div 100/-7",  MD_DIV,   32'd100,       32'hFFFF_FFF9, 1'b1);

        // Randomized operations, with non-issuing traffic on odd iterations
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            run_md("rand", 4'($urandom_range(1, 4)), ra, rb, bit'(i % 2));
        end

        // Dependent MFLO stalls until the engine frees, then reads the new LO
        exp = md_ref(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        ID_EX_ReadData1 = 32'hFFFF_FFFE; ID_EX_ReadData2 = 32'd3;
        ex_valid = 1'b1; md_op = MD_MULT;
        step();
        md_op = MD_MFLO;
        cyc = 0; track = 1'b1;
        while (md_busy === 1'b1 && cyc < 200) begin
            if (md_stall !== 1'b1) track = 1'b0;
            step();
            cyc++;
        end
        check("mflo stall while busy", 64'(track), 64'(1));
        check("mflo stall released", 64'(md_stall), 64'(0));
        check("mflo result", 64'(md_result), 64'(exp[31:0]));
        m_hi = exp[63:32]; m_lo = exp[31:0];
        md_op = MD_MFHI;
        #1;
        check("mfhi result", 64'(md_result), 64'(m_hi));
        md_op = MD_MTHI;
        #1;
        check("md_result other", 64'(md_result), 64'(0));
        idle_inputs();
        step();

        // Flushed DIV is never accepted
        ID_EX_ReadData1 = 32'd50; ID_EX_ReadData2 = 32'd3;
        ex_valid = 1'b1; flush = 1'b1; md_op = MD_DIV;
        #1;
        check("flush no stall", 64'(md_stall), 64'(0));
        step();
        check("flush busy", 64'(md_busy), 64'(0));
        check("flush hilo", {hi, lo}, {m_hi, m_lo});
        idle_inputs();
        step();

        // Reset in the middle of a DIV aborts it
        ID_EX_ReadData1 = 32'd1000; ID_EX_ReadData2 = 32'd7;
        ex_valid = 1'b1; md_op = MD_DIV;
        step();
        idle_inputs();
        repeat (10) step();
        check("div mid busy", 64'(md_busy), 64'(1));
        rst = 1'b1;
        #1;
        check("mid rst hilo", {hi, lo}, 64'(0));
        check("mid rst busy", 64'(md_busy), 64'(0));
        m_hi = '0; m_lo = '0;
        step();
        rst = 1'b0;
        step();

        // MTHI / MTLO through forwarded operand A
        ForwardA = FWD_EXMEM; EX_MEM_ALUResult = 32'h55;
        ex_valid = 1'b1; md_op = MD_MTHI;
        step();
        check("mthi hi", 64'(hi), 64'(32'h55));
        check("mthi lo", 64'(lo), 64'(0));
        ForwardA = FWD_MEMWB; MEM_WB_WriteData = 32'hCAFE_F00D; md_op = MD_MTLO;
        step();
        check("mtlo lo", 64'(lo), 64'(32'hCAFE_F00D));
        check("mtlo busy", 64'(md_busy), 64'(0));
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
